// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the block-RAM stream reader.
package bram_reader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/bram_reader_fifo2.sv
// Two-entry in-order FIFO; head is always entry 0, entries shift on pop.
module bram_reader_fifo2
  import bram_reader_pkg::*;
#(
  parameter int BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [BITS-1:0]  din,
  output logic [CNT_W-1:0] cnt,
  output logic [BITS-1:0]  head
);
  logic [FIFO_DEPTH-1:0][BITS-1:0] mem;

  assign head = mem[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          mem[cnt[0]] <= din;
          cnt         <= cnt + 1'b1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          cnt    <= cnt - 1'b1;
        end
        2'b11: begin
          // occupancy unchanged; new word lands behind whatever remains
          if (cnt == CNT_W'(2)) begin
            mem[0] <= mem[1];
            mem[1] <= din;
          end else begin
            mem[0] <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/bram_stream_reader.sv
// Walks a RAM address range with one-cycle-latency reads and returns the
// words as a ready/valid stream, using a 2-entry FIFO as read credit.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int BITS      = 2,
  parameter int ADDR_BITS = 13,
  parameter int LEN_BITS  = 14
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [LEN_BITS-1:0]  length,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic                 ram_ssr,
  output logic [ADDR_BITS-1:0] ram_addr,
  input  logic [BITS-1:0]      ram_dout,
  output logic                 out_valid,
  output logic [BITS-1:0]      out_data,
  input  logic                 out_ready
);
  state_t               state;
  logic [ADDR_BITS-1:0] addr, addr_q;
  logic [LEN_BITS-1:0]  rem;
  logic                 inflight;
  logic [CNT_W-1:0]     cnt;
  logic                 pop, issue;
  logic [2:0]           occ;

  assign pop       = out_valid & out_ready;
  assign out_valid = (cnt != '0);
  // words the FIFO will hold after this cycle, counting the read in flight
  assign occ       = 3'(cnt) + 3'(inflight) - 3'(pop);
  assign issue     = (state == RUN) && (rem != '0) && (occ <= 3'd1);

  assign ram_en    = issue;
  assign ram_addr  = issue ? addr : addr_q;
  assign ram_we    = 1'b0;
  assign ram_ssr   = 1'b0;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      addr_q   <= '0;
      rem      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        addr   <= addr + ADDR_BITS'(1);
        addr_q <= addr;
        rem    <= rem - LEN_BITS'(1);
      end
      case (state)
        IDLE: if (start) begin
          if (length != '0) begin
            addr  <= start_addr;
            rem   <= length;
            state <= RUN;
          end else begin
            state <= FIN;
          end
        end
        RUN:   if (issue && rem == LEN_BITS'(1)) state <= DRAIN;
        DRAIN: if (occ == 3'd0) state <= FIN;
        FIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  bram_reader_fifo2 #(.BITS(BITS)) u_fifo (
    .clk  (CLK),
    .rst  (reset),
    .push (inflight),
    .pop  (pop),
    .din  (ram_dout),
    .cnt  (cnt),
    .head (out_data)
  );
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: RAM model, expected-word queue and per-cycle stream checks.
module tb_bram_stream_reader;
  logic        CLK = 1'b0, reset = 1'b1, start = 1'b0;
  logic [12:0] start_addr = '0;
  logic [13:0] length = '0;
  logic        busy, done, ram_en, ram_we, ram_ssr, out_valid;
  logic        out_ready = 1'b0;
  logic [12:0] ram_addr;
  logic [1:0]  ram_dout = '0, out_data;

  bram_stream_reader #(.BITS(2), .ADDR_BITS(13), .LEN_BITS(14)) dut (
    .CLK(CLK), .reset(reset), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .ram_en(ram_en), .ram_we(ram_we), .ram_ssr(ram_ssr),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  logic [1:0] mem [8192];
  always @(posedge CLK) if (ram_en) ram_dout <= mem[ram_addr];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0, passed = 0;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // per-transfer model state and observations
  int start_cyc = 0, xa = 0, xn = 0, mode = 0;
  logic [1:0] exp_q[$];
  logic [1:0] pop_data[$];
  int pop_cyc[$];
  int en_addr[$];
  int n_en, n_pop, n_done, n_valid, first_en, last_en, done_cyc, busy_first, busy_last, en_at10;
  logic prev_stall = 1'b0;
  logic [1:0] prev_data = '0;

  // sink ready patterns, driven after the start task has set up the transfer
  initial forever begin
    @(posedge CLK); #2;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = ((cyc - start_cyc) % 3 == 0);
      2: out_ready = ($urandom_range(0, 9) < 7);
      3: out_ready = ((cyc - start_cyc) >= 11);
      default: out_ready = 1'b0;
    endcase
  end

  initial forever begin
    int rel;
    @(negedge CLK);
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      rel = cyc - start_cyc;
      chk("credit_bound", int'((n_en - n_pop) <= 2), 1);
      if (ram_en) begin
        chk("ram_addr", ram_addr, (xa + n_en) % 8192);
        n_en++;
        en_addr.push_back(ram_addr);
        if (first_en < 0) first_en = rel;
        last_en = rel;
        if (n_en > xn) chk("extra_read", n_en, xn);
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid) n_valid++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("pop_when_empty", exp_q.size(), 1);
        else chk("data", out_data, exp_q.pop_front());
        n_pop++;
        pop_data.push_back(out_data);
        pop_cyc.push_back(rel);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin n_done++; done_cyc = rel; end
      if (busy) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (rel == 10) en_at10 = n_en;
    end
  end

  task automatic start_xfer(input int a, input int n, input int m);
    @(posedge CLK); #1;
    mode = m; start_cyc = cyc; xa = a; xn = n;
    n_en = 0; n_pop = 0; n_done = 0; n_valid = 0; first_en = -1; last_en = -1;
    done_cyc = -1; busy_first = -1; busy_last = -1; en_at10 = -1;
    exp_q.delete(); pop_data.delete(); pop_cyc.delete(); en_addr.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(a + i) % 8192]);
    start = 1'b1; start_addr = 13'(a); length = 14'(n);
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      if (n_done != 0) break;
    end
    chk("done_once", n_done, 1);
    @(posedge CLK); #1;
    chk("idle_after_done", busy, 0);
    chk("reads_total", n_en, xn);
    chk("pops_total", n_pop, xn);
    chk("model_drained", exp_q.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
  endtask

  initial begin
    int lit_data[4];
    int lit_addr[4];
    for (int i = 0; i < 8192; i++) mem[i] = 2'($urandom);
    mem[16] = 2'd1; mem[17] = 2'd2; mem[18] = 2'd3; mem[19] = 2'd0;
    lit_data = '{1, 2, 3, 0};
    lit_addr = '{13'h1FFE, 13'h1FFF, 0, 1};

    repeat (3) @(posedge CLK);
    #1;
    chk_zero_outputs("reset");
    chk("ram_we", ram_we, 0);
    chk("ram_ssr", ram_ssr, 0);
    reset = 1'b0;

    // always-ready transfer with fixed timing
    start_xfer(16, 4, 0);
    wait_done(100);
    chk("t1_first_en", first_en, 1);
    chk("t1_last_en", last_en, 4);
    chk("t1_done_cyc", done_cyc, 7);
    chk("t1_busy_first", busy_first, 1);
    chk("t1_busy_last", busy_last, 7);
    chk("t1_first_pop", (pop_cyc.size() > 0) ? pop_cyc[0] : -1, 3);
    chk("t1_last_pop", (pop_cyc.size() > 3) ? pop_cyc[3] : -1, 6);
    for (int i = 0; i < 4; i++) chk("t1_data_lit", (i < pop_data.size()) ? int'(pop_data[i]) : -1, lit_data[i]);

    // toggling sink
    start_xfer(16, 4, 1);
    wait_done(100);
    for (int i = 0; i < 4; i++) chk("t2_data_lit", (i < pop_data.size()) ? int'(pop_data[i]) : -1, lit_data[i]);

    // address wrap
    start_xfer(13'h1FFE, 4, 0);
    wait_done(100);
    for (int i = 0; i < 4; i++) chk("t3_wrap_addr", (i < en_addr.size()) ? en_addr[i] : -1, lit_addr[i]);

    // zero length
    start_xfer(5, 0, 0);
    wait_done(100);
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_busy_first", busy_first, 1);
    chk("t4_busy_last", busy_last, 1);
    chk("t4_no_valid", n_valid, 0);

    // second start while running is ignored
    start_xfer(200, 8, 0);
    start = 1'b1; start_addr = 13'h100; length = 14'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done(100);
    chk("t5_done_cyc", done_cyc, 11);

    // reset while draining with two words buffered
    start_xfer(32, 2, 4);
    repeat (8) @(posedge CLK);
    #1;
    chk("t6_reads", n_en, 2);
    chk("t6_valid", out_valid, 1);
    chk("t6_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    @(posedge CLK); #1;
    reset = 1'b0;
    start_xfer(16, 4, 0);
    wait_done(100);
    chk("t6_done_cyc", done_cyc, 7);
    chk("t6_first_pop", (pop_cyc.size() > 0) ? pop_cyc[0] : -1, 3);
    for (int i = 0; i < 4; i++) chk("t6_data_lit", (i < pop_data.size()) ? int'(pop_data[i]) : -1, lit_data[i]);

    // long stall then release
    start_xfer(64, 8, 3);
    wait_done(200);
    chk("t7_reads_stalled", en_at10, 2);
    chk("t7_first_pop", (pop_cyc.size() > 0) ? pop_cyc[0] : -1, 11);
    chk("t7_last_pop", (pop_cyc.size() > 7) ? pop_cyc[7] : -1, 18);
    chk("t7_valid_cycles", n_valid, 16);
    chk("t7_done_cyc", done_cyc, 19);

    // randomized transfers with random backpressure
    for (int t = 0; t < 25; t++) begin
      start_xfer($urandom_range(0, 8191), $urandom_range(0, 20), 2);
      wait_done(300);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
